seq_det_ctrl: RTL
=================

# seq_det_ctrl

Frame-level controller for the serial sequence detector. It accepts parallel words over a valid/ready handshake and serialises them MSB-first into a programmable 1–4-bit pattern matcher. It counts matches per frame and signals frame completion. It sits between a word-oriented producer and downstream logic that needs per-bit match pulses and a per-frame match count.

## Interface
- WORD_W, 8: input word width, bits per accepted word (≥2)
- CNT_W, 8: match counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low; one clock, sampled on rising edge of clk
- cfg_pattern  in  4  pattern; bit 0 = most recent bit compared
- cfg_len  in  3  pattern length 1–4; values 0 and 5–7 are treated as 4
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history cleared after each match
- cfg_we  in  1  config load strobe
- s_valid  in  1  word valid
- s_data  in  WORD_W  word, shifted MSB first
- s_last  in  1  word is last of frame
- s_ready  out  1  word accepted when s_valid & s_ready
- match_pulse  out  1  one-cycle pulse per detected match
- match_count  out  CNT_W  saturating match count for current/last frame
- busy  out  1  frame in progress (first word accepted, done not yet issued)
- done  out  1  one-cycle frame-complete pulse

## Operation
- States: IDLE, SHIFT, DONE. s_ready = (state == IDLE).
- IDLE:
  - On s_valid & s_ready: capture s_data and s_last, set bit index to WORD_W-1, go to SHIFT.
  - If busy == 0, the same edge clears match_count, clears the history valid count (hcnt) and sets busy.
- SHIFT:
  - One bit per cycle, MSB first: history h <= {h[2:0], bit}; hcnt saturates at 4.
  - Match condition: (hcnt after update ≥ len) and the low len bits of the updated h equal the low len bits of the pattern.
  - On a match: match_pulse <= 1 and match_count increments, saturating at 2^CNT_W-1. If cfg_overlap == 0, hcnt <= 0.
  - After the bit-0 edge: if last == 1 go to DONE, else go to IDLE. History and hcnt are retained across words within a frame.
- DONE: done = 1 for one cycle, busy cleared, then go to IDLE. match_count holds until the next frame's first accept.
- Config registers (pattern, len, overlap):
  - Load on cfg_we only when state == IDLE and busy == 0; ignored otherwise.
  - If cfg_we and a word accept occur on the same edge, the new config applies to that word.
  - Reset values: pattern 4'b1011, len 4, overlap 1.
- Reset, including mid-frame:
  - state IDLE, s_ready 1, busy 0, done 0, match_pulse 0, match_count 0, h 0, hcnt 0, config at reset values.
  - The in-flight word is discarded and no done is issued.

## Timing
- T0 = accept cycle.
- SHIFT occupies T1..T_WORD_W; the bit (WORD_W-k) is processed at the end of Tk.
- match_pulse for a bit processed at the end of Tk is high in Tk+1.
- Last word: DONE in T_WORD_W+1 (done = 1; may coincide with the final match_pulse); IDLE/s_ready in T_WORD_W+2.
- Non-last word: IDLE in T_WORD_W+1.
- Throughput is one word per WORD_W+1 cycles when back-to-back.
- s_data and s_last are sampled only at accept. s_valid is ignored while s_ready = 0; the producer holds it.

## Test plan
- Reset: hold rst_n low 2 cycles with s_valid = 1 → after release s_ready = 1, busy = 0, done = 0, match_pulse = 0, match_count = 0; with rst_n low, no accept occurs.
- Default config, word 0xB6 with last = 1, overlap = 1 → match_pulse in T5 and T8, done in T9, match_count = 2. Same word with overlap = 0 → single pulse in T5, match_count = 1.
- Cross-word frame: 0x01 (last = 0), then 0x60 (last = 1) after a 3-cycle gap → s_ready high during the gap, one match_pulse on the cycle after the 3rd bit of word 2, match_count = 1, busy high throughout, done once.
- cfg_len = 2, cfg_pattern = 4'b0001, overlap = 1, word 0x55 last = 1 → pulses in T3, T5, T7, T9, match_count = 4. A cfg_we to len 1 issued during SHIFT is ignored (count is still 4).
- CNT_W = 2, len = 1, pattern = 1, word 0xFF last = 1 → 8 match_pulses, match_count saturates at 3. The next frame's accept clears it to 0.
- Reset mid-frame: drive rst_n low in T4 of word 0xB6 → next cycle shows reset values, no done, match_count = 0; a subsequent frame behaves as from power-up.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Frame-level controller for the serial sequence detector: accepts parallel words,
// shifts them MSB-first into a 1-4 bit pattern matcher and counts matches per frame.
module seq_det_ctrl #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cfg_pattern,
  input  logic [2:0]        cfg_len,
  input  logic              cfg_overlap,
  input  logic              cfg_we,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned HCNT_W  = 3;
  localparam logic [3:0]  RST_PAT = 4'b1011;
  localparam logic [2:0]  RST_LEN = 3'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [HCNT_W-1:0] HCNT_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WORD_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [2:0]        h_q, h_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [3:0]        pat_q, pat_d;
  logic [2:0]        len_q, len_d;
  logic              ovl_q, ovl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pulse_q, pulse_d;
  logic              ready_q, ready_d;

  logic              accept;
  logic              cfg_load;
  logic              bit_last;
  logic              shift_bit;
  logic [3:0]        h_upd;
  logic [HCNT_W-1:0] hcnt_upd;
  logic [2:0]        len_eff;
  logic [3:0]        len_mask;
  logic              hit;

  assign accept    = s_valid & ready_q;
  assign cfg_load  = cfg_we & (state_q == ST_IDLE) & ~busy_q;
  assign bit_last  = (idx_q == '0);
  assign shift_bit = word_q[idx_q];

  // Matcher: history after shifting in the current bit, compared over len bits.
  assign h_upd    = {h_q, shift_bit};
  assign hcnt_upd = (hcnt_q >= HCNT_MAX) ? HCNT_MAX : hcnt_q + HCNT_W'(1);
  assign len_eff  = ((len_q == 3'd0) || (len_q > 3'd4)) ? 3'd4 : len_q;
  assign len_mask = 4'((5'd1 << len_eff) - 5'd1);
  assign hit      = (hcnt_upd >= len_eff) && ((h_upd & len_mask) == (pat_q & len_mask));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (bit_last) state_d = last_q ? ST_DONE : ST_IDLE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    h_d     = h_q;
    hcnt_d  = hcnt_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    pulse_d = 1'b0;
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);

    // A load on the accept edge takes effect for that word, since matching starts next cycle.
    if (cfg_load) begin
      pat_d = cfg_pattern;
      len_d = cfg_len;
      ovl_d = cfg_overlap;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          word_d = s_data;
          last_d = s_last;
          idx_d  = IDX_W'(WORD_W - 1);
          if (!busy_q) begin
            cnt_d  = '0;
            hcnt_d = '0;
            busy_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        h_d    = h_upd[2:0];
        hcnt_d = hcnt_upd;
        idx_d  = idx_q - IDX_W'(1);
        if (hit) begin
          pulse_d = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (!ovl_q) hcnt_d = '0;
        end
      end
      ST_DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      h_q     <= '0;
      hcnt_q  <= '0;
      pat_q   <= RST_PAT;
      len_q   <= RST_LEN;
      ovl_q   <= 1'b1;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      h_q     <= h_d;
      hcnt_q  <= hcnt_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
      ready_q <= ready_d;
    end
  end

  assign s_ready     = ready_q;
  assign match_pulse = pulse_q;
  assign match_count = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
